// File: rtl/config_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader.
//   - default parameter values for chain length, word width and timeout
//   - loader FSM state encoding
//   - counter width helper used by the top and the serializer
package config_chain_loader_pkg;

  localparam int CHAIN_LEN_DEF = 256;
  localparam int WORD_W_DEF    = 8;
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } cfg_state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Captures one bitstream word and presents it LSB first, one bit per shift.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (index only)
//   load        - capture word_data, restart at bit 0
//   shift       - advance to the next bit
//   word_data   - incoming bitstream word
//   head_bit    - bit currently presented to the chain head
//   last_bit    - current bit is the top bit of the captured word
module cfg_word_serializer
  import config_chain_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word_data,
  output logic              head_bit,
  output logic              last_bit
);

  localparam int              IDX_W    = cnt_width(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;

  // Data register carries no reset: the chain head output is gated by
  // shift_en in the top, so stale contents never reach the fabric.
  always_ff @(posedge clk) begin
    if (load)
      word_q <= word_data;
    else if (shift)
      word_q <= word_q >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idx_q <= '0;
    else if (load)
      idx_q <= '0;
    else if (shift)
      idx_q <= idx_q + 1'b1;
  end

  assign head_bit = word_q[0];
  assign last_bit = (idx_q == LAST_IDX);

endmodule

// File: rtl/config_chain_loader.sv
// Loads a serial configuration chain from a word-wide bitstream.
// Words are accepted with a valid/ready handshake and shifted into the chain
// LSB first; the fabric is held isolated until the whole chain is loaded.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   start, abort           - begin / cancel a programming sequence
//   word_data, word_valid  - bitstream word input
//   word_ready             - word accepted this cycle (LOAD only)
//   ccff_head, shift_en    - serial data and enable for the chain
//   isol_n                 - 0 keeps the fabric isolated
//   busy, done, error      - sequence status (error is a LOAD timeout)
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              shift_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int               BIT_W    = cnt_width(CHAIN_LEN);
  localparam int               TMO_W    = cnt_width(TIMEOUT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  cfg_state_t       state;
  logic [BIT_W-1:0] bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ser_load;
  logic             ser_shift;
  logic             ser_head;
  logic             ser_last;

  // Abort wins over both the handshake and the shift.
  assign ser_load  = (state == ST_LOAD) && word_valid && !abort;
  assign ser_shift = (state == ST_SHIFT) && !abort;

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .shift     (ser_shift),
    .word_data (word_data),
    .head_bit  (ser_head),
    .last_bit  (ser_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (word_valid) begin
            state   <= ST_SHIFT;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            // The chain end can fall mid-word; the remaining upper bits of
            // the final word are simply never shifted.
            if (bit_cnt == LAST_BIT)
              state <= ST_DONE;
            else if (ser_last)
              state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode the state register only.
  assign word_ready = (state == ST_LOAD);
  assign shift_en   = (state == ST_SHIFT);
  assign ccff_head  = shift_en && ser_head;
  assign busy       = (state == ST_LOAD) || (state == ST_SHIFT);
  assign isol_n     = (state == ST_DONE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          ccff_head;
  logic          shift_en;
  logic          isol_n;
  logic          busy;
  logic          done;
  logic          error;

  config_chain_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .ccff_head  (ccff_head),
    .shift_en   (shift_en),
    .isol_n     (isol_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [WW-1:0] words [3] = '{8'hA5, 8'h3C, 8'h0F};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sequence is "active" until CL bits have left a
  // queue of pending chain bits; an empty queue while active means the
  // loader is waiting for the next word.
  bit m_act, m_ld, m_fail;
  bit mq[$];
  int m_sent, m_wait;

  task automatic model_reset();
    m_act = 0; m_ld = 0; m_fail = 0; m_sent = 0; m_wait = 0;
    mq.delete();
  endtask

  // Advance the model by one clock using the inputs that the next rising
  // edge will sample.
  task automatic model_step();
    if (!m_act) begin
      if (start) begin
        m_act = 1; m_ld = 0; m_fail = 0; m_sent = 0; m_wait = 0;
        mq.delete();
      end
    end else if (abort) begin
      m_act = 0;
      mq.delete();
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
      m_sent++;
      if (m_sent == CL) begin
        m_act = 0;
        m_ld  = 1;
      end
    end else if (word_valid) begin
      for (int b = 0; b < WW && b < CL - m_sent; b++)
        mq.push_back(word_data[b]);
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == TO) begin
        m_act  = 0;
        m_fail = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      if (chk_en) begin
        chk("busy",       busy,       m_act);
        chk("word_ready", word_ready, m_act && mq.size() == 0);
        chk("shift_en",   shift_en,   m_act && mq.size() > 0);
        chk("ccff_head",  ccff_head,  (m_act && mq.size() > 0) ? mq[0] : 0);
        chk("isol_n",     isol_n,     m_ld);
        chk("done",       done,       m_ld);
        chk("error",      error,      m_fail);
      end
      if (!reset) model_step();
    end
  end

  // One programming sequence: pulses start, feeds the three words, optionally
  // holds word_valid low for 'gap' ready cycles per word, pulses start after
  // 'start_at' shifts and asserts abort during shift number 'abort_after'.
  task automatic run_seq(input int gap, input int abort_after, input int start_at,
                         output int shifts, output int hs, output int gaps,
                         output logic [CL-1:0] seq, output bit fin);
    int idx;
    int rdy_wait;
    bit hs_now;
    bit ended;
    shifts = 0; hs = 0; gaps = 0; seq = '0; fin = 0;
    idx = 0; rdy_wait = 0; ended = 0;
    word_data  = words[0];
    word_valid = (gap == 0);
    start      = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 400 && !ended; n++) begin
      @(negedge clk);
      if (!busy) begin
        ended = 1;
        fin   = done;
      end else begin
        hs_now = word_ready && word_valid;
        if (word_ready && !word_valid) begin
          gaps++;
          rdy_wait++;
        end
        if (shift_en) begin
          if (shifts < CL) seq[shifts] = ccff_head;
          shifts++;
        end
        @(posedge clk); #1;
        if (hs_now) begin
          hs++;
          idx++;
          rdy_wait = 0;
        end
        word_data  = words[(idx < 3) ? idx : 2];
        word_valid = (idx < 3) && (rdy_wait >= gap);
        start      = (start_at > 0) && (shifts == start_at);
        abort      = (abort_after > 0) && (shifts == abort_after - 1);
      end
    end
    chk("seq_budget", ended, 1);
    @(posedge clk); #1;
    word_valid = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  int               shifts, hs, gaps, cnt;
  logic [CL-1:0]    seq;
  bit               fin;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_data = '0; word_valid = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;

    // Reset values
    chk("rst_busy",   busy,       0);
    chk("rst_ready",  word_ready, 0);
    chk("rst_shift",  shift_en,   0);
    chk("rst_head",   ccff_head,  0);
    chk("rst_isol",   isol_n,     0);
    chk("rst_done",   done,       0);
    chk("rst_error",  error,      0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Back-to-back words A5, 3C, 0F
    run_seq(0, 0, 0, shifts, hs, gaps, seq, fin);
    chk("t1_done",   fin,    1);
    chk("t1_shifts", shifts, 20);
    chk("t1_hs",     hs,     3);
    chk("t1_seq",    int'(seq), 32'hF3CA5);
    chk("t1_isol",   isol_n, 1);

    // abort in DONE has no effect
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(posedge clk); #1;
    chk("done_abort_done", done,   1);
    chk("done_abort_isol", isol_n, 1);

    // Five-cycle valid gaps before every word
    run_seq(5, 0, 0, shifts, hs, gaps, seq, fin);
    chk("t2_done",   fin,    1);
    chk("t2_shifts", shifts, 20);
    chk("t2_hs",     hs,     3);
    chk("t2_gaps",   gaps,   15);
    chk("t2_seq",    int'(seq), 32'hF3CA5);

    // start pulsed mid-SHIFT is ignored
    run_seq(0, 0, 4, shifts, hs, gaps, seq, fin);
    chk("t3_done",   fin,    1);
    chk("t3_shifts", shifts, 20);

    // start in DONE drops isolation release and begins a new sequence
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t3_restart_isol", isol_n, 0);
    chk("t3_restart_busy", busy,   1);
    chk("t3_restart_done", done,   0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("t3_abort_busy", busy,   0);
    chk("t3_abort_isol", isol_n, 0);

    // Timeout: no valid word ever arrives
    word_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        chk("t4_err_c15",  error, 0);
        chk("t4_busy_c15", busy,  1);
      end
      if (i == 16) begin
        chk("t4_err_c16",  error,  1);
        chk("t4_busy_c16", busy,   0);
        chk("t4_isol_c16", isol_n, 0);
      end
    end
    @(posedge clk); #1;
    chk("t4_err_sticky", error, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t4_err_clear", error, 0);
    chk("t4_reload",    word_ready, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;

    // Abort after 10 shifted bits, then a clean full load
    run_seq(0, 10, 0, shifts, hs, gaps, seq, fin);
    chk("t5_done",   fin,      0);
    chk("t5_shifts", shifts,   10);
    chk("t5_hs",     hs,       2);
    chk("t5_shift",  shift_en, 0);
    chk("t5_isol",   isol_n,   0);
    chk("t5_busy",   busy,     0);
    run_seq(0, 0, 0, shifts, hs, gaps, seq, fin);
    chk("t5_redo_done",   fin,    1);
    chk("t5_redo_shifts", shifts, 20);

    // Asynchronous reset in the middle of SHIFT
    word_data  = words[0];
    word_valid = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_shift", shift_en, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_shift", shift_en,   0);
    chk("t6_rst_head",  ccff_head,  0);
    chk("t6_rst_busy",  busy,       0);
    chk("t6_rst_ready", word_ready, 0);
    chk("t6_rst_isol",  isol_n,     0);
    chk("t6_rst_done",  done,       0);
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (shift_en) cnt++;
    end
    chk("t6_no_shift", cnt, 0);
    @(posedge clk); #1 word_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
